scramble_seq_checker: RTL and testbench
=======================================

// Module: scramble_seq_checker
// PURPOSE
//  Receive-side checker for the 14-state scrambled 4-bit count sequence
//  (8,7,11,4,9,2,5,12,6,3,15,1,14,13, then 8 again).
//  - Decodes each sampled code to its ordinal index 0..13.
//  - Acquires and tracks lock on the sequence, flags sequence and invalid-code errors.
//  - Keeps a saturating error count.
//  Sits at the far end of a link driven by the scrambled counter.
// PARAMETERS
//  LOCK_COUNT   3  consecutive in-order codes (incl. first) needed to declare lock; >=2
//  UNLOCK_ERRS  2  consecutive mismatches in LOCKED that drop lock; >=1
//  ERR_CNT_W    8  width of err_count
// PORTS
//  clk          in   1          clock, rising edge
//  reset        in   1          asynchronous, active-high reset
//  code_valid   in   1          code_in is sampled this cycle
//  code_in      in   4          received scrambled code
//  clear_err    in   1          synchronous clear of err_count
//  index_out    out  4          decoded index of last valid code
//  index_valid  out  1          1-cycle pulse: index_out updated
//  locked       out  1          level: tracker in LOCKED
//  seq_err      out  1          1-cycle pulse: out-of-order code while LOCKED
//  invalid_code out  1          1-cycle pulse: sampled code is 0 or 10
//  wrap_pulse   out  1          1-cycle pulse: in-order 13->8 transition while LOCKED
//  err_count    out  ERR_CNT_W  saturating count of seq_err + invalid_code events while LOCKED
// BEHAVIOUR
//  - Reset: all outputs 0, state HUNT, internal counters 0, expected code 8.
//  - Decode table (code->idx): 8-0 7-1 11-2 4-3 9-4 2-5 5-6 12-7 6-8 3-9 15-10 1-11 14-12 13-13.
//    Codes 0 and 10 are invalid.
//  - Latency: all outputs registered. Effects of a code sampled at edge N appear after edge N+1.
//    No sampling when code_valid=0; outputs hold, pulses 0.
//  - index_out / index_valid:
//    - Valid code: index_out <= idx, index_valid pulses.
//    - Invalid code: index_out holds, index_valid 0, invalid_code pulses (any state).
//  - Tracker FSM, state HUNT:
//    - Valid code -> expected <= succ(code), good_cnt <= 1, go SYNC.
//    - Invalid code -> stay HUNT.
//  - State SYNC:
//    - code == expected -> good_cnt++, expected <= succ.
//      - good_cnt reaching LOCK_COUNT -> go LOCKED, bad_cnt <= 0.
//    - Valid mismatch -> restart: good_cnt <= 1, expected <= succ(code).
//    - Invalid code -> HUNT.
//  - State LOCKED (locked=1):
//    - Match -> bad_cnt <= 0, expected <= succ.
//      - If matched code is 8 (prior expected 13 matched) -> wrap_pulse.
//    - Mismatch or invalid:
//      - seq_err pulses on a valid mismatch only.
//      - err_count += 1, bad_cnt++.
//      - expected <= succ(expected) (flywheel; does not resync to received code).
//      - bad_cnt reaching UNLOCK_ERRS -> HUNT, locked drops next cycle.
//  - Errors in HUNT/SYNC never increment err_count.
//  - err_count saturates at all-ones.
//    - clear_err has priority: clear and increment in the same cycle -> 0.
//  - succ(13)=8: sequence wraps; the codes themselves have no other ordering.
//  - Reset mid-stream: immediate return to reset values. The next valid code starts acquisition from HUNT.
// TESTING
//  1 Reset, send 8,7,11 back-to-back -> index 0,1,2.
//    locked=1 the cycle after 11 is registered, no errors.
//  2 Locked, send two full 14-code periods -> wrap_pulse exactly once at the second 8.
//    err_count=0, index_out=13 at end.
//  3 Locked after 11, send 3 (expect 4) then 9 -> seq_err once, err_count=1.
//    locked stays 1, 9 matches with no error.
//  4 Locked, send 3 then 6 (two mismatches) -> err_count=2, locked=0.
//    Next 8,7,11 relocks.
//  5 HUNT: send 0 then 10 -> invalid_code pulses twice, index_valid 0, err_count 0.
//    In LOCKED, code 10 -> invalid_code=1, seq_err=0, err_count +1.
//  6 ERR_CNT_W=2: force 5 errors (relocking between) -> err_count holds at 3.
//    clear_err coincident with an error -> 0. Assert reset mid-SYNC -> all outputs 0 immediately.

Source files
------------

// File: rtl/scramble_seq_checker.sv
// Receive-side checker for the 14-state scrambled 4-bit count sequence:
// decodes codes to indices, acquires/tracks lock, flags errors, counts errors while locked.
module scramble_seq_checker #(
  parameter int unsigned LOCK_COUNT  = 3,
  parameter int unsigned UNLOCK_ERRS = 2,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 code_valid,
  input  logic [3:0]           code_in,
  input  logic                 clear_err,
  output logic [3:0]           index_out,
  output logic                 index_valid,
  output logic                 locked,
  output logic                 seq_err,
  output logic                 invalid_code,
  output logic                 wrap_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned     GW         = $clog2(LOCK_COUNT + 1);
  localparam int unsigned     BW         = $clog2(UNLOCK_ERRS + 1);
  localparam logic [GW-1:0]   LOCK_TGT   = GW'(LOCK_COUNT);
  localparam logic [BW-1:0]   UNLOCK_TGT = BW'(UNLOCK_ERRS);
  localparam logic [3:0]      FIRST_CODE = 4'd8;

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  // {valid, index}; codes 0 and 10 decode as invalid
  function automatic logic [4:0] decode(input logic [3:0] c);
    logic [4:0] r;
    case (c)
      4'd8:    r = {1'b1, 4'd0};
      4'd7:    r = {1'b1, 4'd1};
      4'd11:   r = {1'b1, 4'd2};
      4'd4:    r = {1'b1, 4'd3};
      4'd9:    r = {1'b1, 4'd4};
      4'd2:    r = {1'b1, 4'd5};
      4'd5:    r = {1'b1, 4'd6};
      4'd12:   r = {1'b1, 4'd7};
      4'd6:    r = {1'b1, 4'd8};
      4'd3:    r = {1'b1, 4'd9};
      4'd15:   r = {1'b1, 4'd10};
      4'd1:    r = {1'b1, 4'd11};
      4'd14:   r = {1'b1, 4'd12};
      4'd13:   r = {1'b1, 4'd13};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] encode(input logic [3:0] i);
    logic [3:0] c;
    case (i)
      4'd0:    c = 4'd8;
      4'd1:    c = 4'd7;
      4'd2:    c = 4'd11;
      4'd3:    c = 4'd4;
      4'd4:    c = 4'd9;
      4'd5:    c = 4'd2;
      4'd6:    c = 4'd5;
      4'd7:    c = 4'd12;
      4'd8:    c = 4'd6;
      4'd9:    c = 4'd3;
      4'd10:   c = 4'd15;
      4'd11:   c = 4'd1;
      4'd12:   c = 4'd14;
      4'd13:   c = 4'd13;
      default: c = 4'd8;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] succ(input logic [3:0] c);
    logic [4:0] d;
    d = decode(c);
    return encode((d[3:0] == 4'd13) ? 4'd0 : d[3:0] + 4'd1);
  endfunction

  state_t                 state_q, state_d;
  logic                   smp_valid_q, smp_valid_d;
  logic [3:0]             smp_code_q, smp_code_d;
  logic                   smp_clr_q, smp_clr_d;
  logic [3:0]             expected_q, expected_d;
  logic [GW-1:0]          good_cnt_q, good_cnt_d;
  logic [BW-1:0]          bad_cnt_q, bad_cnt_d;
  logic [3:0]             index_out_q, index_out_d;
  logic                   index_valid_q, index_valid_d;
  logic                   locked_q, locked_d;
  logic                   seq_err_q, seq_err_d;
  logic                   invalid_code_q, invalid_code_d;
  logic                   wrap_pulse_q, wrap_pulse_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
  logic [4:0]             dec;
  logic                   err_inc;

  // Sample stage (smp_*) captures inputs; the tracker acts on them one edge later.
  always_comb begin
    smp_valid_d    = code_valid;
    smp_code_d     = code_in;
    smp_clr_d      = clear_err;
    state_d        = state_q;
    expected_d     = expected_q;
    good_cnt_d     = good_cnt_q;
    bad_cnt_d      = bad_cnt_q;
    index_out_d    = index_out_q;
    index_valid_d  = 1'b0;
    seq_err_d      = 1'b0;
    invalid_code_d = 1'b0;
    wrap_pulse_d   = 1'b0;
    err_inc        = 1'b0;
    dec            = decode(smp_code_q);

    if (smp_valid_q) begin
      if (dec[4]) begin
        index_out_d   = dec[3:0];
        index_valid_d = 1'b1;
      end else begin
        invalid_code_d = 1'b1;
      end

      case (state_q)
        HUNT: begin
          if (dec[4]) begin
            expected_d = succ(smp_code_q);
            good_cnt_d = GW'(1);
            state_d    = SYNC;
          end
        end
        SYNC: begin
          if (!dec[4]) begin
            state_d = HUNT;
          end else if (smp_code_q == expected_q) begin
            expected_d = succ(expected_q);
            good_cnt_d = good_cnt_q + GW'(1);
            if (good_cnt_d == LOCK_TGT) begin
              state_d   = LOCKED;
              bad_cnt_d = '0;
            end
          end else begin
            expected_d = succ(smp_code_q);
            good_cnt_d = GW'(1);
          end
        end
        LOCKED: begin
          expected_d = succ(expected_q);
          if (dec[4] && smp_code_q == expected_q) begin
            bad_cnt_d    = '0;
            wrap_pulse_d = (smp_code_q == FIRST_CODE);
          end else begin
            // flywheel: keep advancing the expected code instead of resyncing
            seq_err_d = dec[4];
            err_inc   = 1'b1;
            bad_cnt_d = bad_cnt_q + BW'(1);
            if (bad_cnt_d == UNLOCK_TGT) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == LOCKED);

    if (smp_clr_q) begin
      err_count_d = '0;
    end else if (err_inc && err_count_q != '1) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp_valid_q    <= 1'b0;
      smp_code_q     <= '0;
      smp_clr_q      <= 1'b0;
      state_q        <= HUNT;
      expected_q     <= FIRST_CODE;
      good_cnt_q     <= '0;
      bad_cnt_q      <= '0;
      index_out_q    <= '0;
      index_valid_q  <= 1'b0;
      locked_q       <= 1'b0;
      seq_err_q      <= 1'b0;
      invalid_code_q <= 1'b0;
      wrap_pulse_q   <= 1'b0;
      err_count_q    <= '0;
    end else begin
      smp_valid_q    <= smp_valid_d;
      smp_code_q     <= smp_code_d;
      smp_clr_q      <= smp_clr_d;
      state_q        <= state_d;
      expected_q     <= expected_d;
      good_cnt_q     <= good_cnt_d;
      bad_cnt_q      <= bad_cnt_d;
      index_out_q    <= index_out_d;
      index_valid_q  <= index_valid_d;
      locked_q       <= locked_d;
      seq_err_q      <= seq_err_d;
      invalid_code_q <= invalid_code_d;
      wrap_pulse_q   <= wrap_pulse_d;
      err_count_q    <= err_count_d;
    end
  end

  assign index_out    = index_out_q;
  assign index_valid  = index_valid_q;
  assign locked       = locked_q;
  assign seq_err      = seq_err_q;
  assign invalid_code = invalid_code_q;
  assign wrap_pulse   = wrap_pulse_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_scramble_seq_checker.sv
// Bench for scramble_seq_checker: directed vector table, hand-written corner sequences,
// and randomized traffic against an index-arithmetic reference model.
module tb_scramble_seq_checker;

  localparam int LOCK_COUNT  = 3;
  localparam int UNLOCK_ERRS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       code_valid = 1'b0;
  logic [3:0] code_in = '0;
  logic       clear_err = 1'b0;

  logic [3:0] index_out, i2_index_out;
  logic       index_valid, locked, seq_err, invalid_code, wrap_pulse;
  logic       i2_index_valid, i2_locked, i2_seq_err, i2_invalid_code, i2_wrap_pulse;
  logic [7:0] err_count;
  logic [1:0] i2_err_count;

  scramble_seq_checker #(.LOCK_COUNT(LOCK_COUNT), .UNLOCK_ERRS(UNLOCK_ERRS), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code_in(code_in), .clear_err(clear_err),
    .index_out(index_out), .index_valid(index_valid), .locked(locked), .seq_err(seq_err),
    .invalid_code(invalid_code), .wrap_pulse(wrap_pulse), .err_count(err_count));

  scramble_seq_checker #(.LOCK_COUNT(LOCK_COUNT), .UNLOCK_ERRS(UNLOCK_ERRS), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code_in(code_in), .clear_err(clear_err),
    .index_out(i2_index_out), .index_valid(i2_index_valid), .locked(i2_locked), .seq_err(i2_seq_err),
    .invalid_code(i2_invalid_code), .wrap_pulse(i2_wrap_pulse), .err_count(i2_err_count));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int seq[14] = '{8, 7, 11, 4, 9, 2, 5, 12, 6, 3, 15, 1, 14, 13};

  // reference model: position in the sequence, run length, consecutive misses
  bit m_lock;
  int m_run, m_miss, m_exp, m_errs;
  int m_idx, m_iv, m_se, m_inv, m_wr;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pos_of(input int c);
    for (int i = 0; i < 14; i++) if (seq[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_run = 0; m_miss = 0; m_exp = 0; m_errs = 0;
    m_idx = 0; m_iv = 0; m_se = 0; m_inv = 0; m_wr = 0;
  endtask

  task automatic model_step(input bit v, input int c, input bit clr);
    int p;
    m_iv = 0; m_se = 0; m_inv = 0; m_wr = 0;
    if (v) begin
      p = pos_of(c);
      if (p >= 0) begin m_idx = p; m_iv = 1; end
      else m_inv = 1;
      if (!m_lock) begin
        if (p < 0) m_run = 0;
        else if (m_run > 0 && p == m_exp) begin
          m_run++;
          m_exp = (m_exp + 1) % 14;
          if (m_run >= LOCK_COUNT) begin m_lock = 1; m_miss = 0; end
        end else begin
          m_run = 1;
          m_exp = (p + 1) % 14;
        end
      end else begin
        if (p >= 0 && p == m_exp) begin
          m_miss = 0;
          if (p == 0) m_wr = 1;
        end else begin
          if (p >= 0) m_se = 1;
          m_errs++;
          m_miss++;
          if (m_miss >= UNLOCK_ERRS) begin m_lock = 0; m_run = 0; end
        end
        m_exp = (m_exp + 1) % 14;
      end
    end
    if (clr) m_errs = 0;
  endtask

  task automatic check_model();
    check("index_out", int'(index_out), m_idx);
    check("index_valid", int'(index_valid), m_iv);
    check("locked", int'(locked), int'(m_lock));
    check("seq_err", int'(seq_err), m_se);
    check("invalid_code", int'(invalid_code), m_inv);
    check("wrap_pulse", int'(wrap_pulse), m_wr);
    check("err_count", int'(err_count), (m_errs > 255) ? 255 : m_errs);
    check("err_count_w2", int'(i2_err_count), (m_errs > 3) ? 3 : m_errs);
  endtask

  // one sample: outputs seen after this edge reflect the previous sample
  task automatic drive(input bit v, input int c, input bit clr);
    @(negedge clk);
    code_valid = v;
    code_in    = 4'(c);
    clear_err  = clr;
    @(posedge clk);
    #1;
    check_model();
    model_step(v, c, clr);
  endtask

  task automatic apply_reset();
    #2;
    reset = 1'b1;
    code_valid = 1'b0;
    clear_err = 1'b0;
    #1;
    check("rst_index_out", int'(index_out), 0);
    check("rst_index_valid", int'(index_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_seq_err", int'(seq_err), 0);
    check("rst_invalid", int'(invalid_code), 0);
    check("rst_wrap", int'(wrap_pulse), 0);
    check("rst_err_count", int'(err_count), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit v; int c; bit clr;
    int e_idx; int e_iv; int e_lk; int e_se; int e_inv; int e_wr; int e_ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit v, int c, bit clr, int idx, int iv, int lk, int se, int inv, int wr, int ec);
    vec_t r;
    r.v = v; r.c = c; r.clr = clr;
    r.e_idx = idx; r.e_iv = iv; r.e_lk = lk; r.e_se = se; r.e_inv = inv; r.e_wr = wr; r.e_ec = ec;
    return r;
  endfunction

  task automatic check_vec(input vec_t e, input int n);
    check($sformatf("tbl%0d_index_out", n), int'(index_out), e.e_idx);
    check($sformatf("tbl%0d_index_valid", n), int'(index_valid), e.e_iv);
    check($sformatf("tbl%0d_locked", n), int'(locked), e.e_lk);
    check($sformatf("tbl%0d_seq_err", n), int'(seq_err), e.e_se);
    check($sformatf("tbl%0d_invalid", n), int'(invalid_code), e.e_inv);
    check($sformatf("tbl%0d_wrap", n), int'(wrap_pulse), e.e_wr);
    check($sformatf("tbl%0d_err_count", n), int'(err_count), e.e_ec);
  endtask

  initial begin
    int wraps, t, tx, r;
    model_reset();
    apply_reset();

    // acquisition, single/double mismatch, invalid codes in HUNT and LOCKED, clear
    vecs.push_back(mk(1, 8, 0,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 7, 0,  1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 11, 0, 2, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 0,  9, 1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 9, 0,  4, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 3, 0,  9, 1, 1, 1, 0, 0, 2));
    vecs.push_back(mk(1, 6, 0,  8, 1, 0, 1, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0,  8, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 10, 0, 8, 0, 0, 0, 1, 0, 3));
    vecs.push_back(mk(1, 0, 0,  8, 0, 0, 0, 1, 0, 3));
    vecs.push_back(mk(1, 8, 0,  0, 1, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 7, 0,  1, 1, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 11, 0, 2, 1, 1, 0, 0, 0, 3));
    vecs.push_back(mk(1, 10, 0, 2, 0, 1, 0, 1, 0, 4));
    vecs.push_back(mk(1, 9, 0,  4, 1, 1, 0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 1,  4, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 0,  5, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].c, vecs[i].clr);
      if (i > 0) check_vec(vecs[i-1], i - 1);
    end
    drive(0, 0, 0);
    check_vec(vecs[vecs.size()-1], vecs.size() - 1);

    // two full periods from reset: exactly one wrap, at the second 8
    apply_reset();
    wraps = 0;
    for (int i = 0; i < 28; i++) begin
      drive(1, seq[i % 14], 0);
      wraps += int'(wrap_pulse);
    end
    drive(0, 0, 0);
    wraps += int'(wrap_pulse);
    check("wrap_count", wraps, 1);
    check("wrap_index_end", int'(index_out), 13);
    check("wrap_err_count", int'(err_count), 0);

    // five isolated errors while locked: 8-bit counts 5, 2-bit saturates at 3
    apply_reset();
    drive(1, 8, 0); drive(1, 7, 0); drive(1, 11, 0);
    t = 3;
    for (int k = 0; k < 5; k++) begin
      drive(1, seq[(t + 5) % 14], 0); t++;
      drive(1, seq[t % 14], 0); t++;
    end
    drive(0, 0, 0);
    check("sat_err8", int'(err_count), 5);
    check("sat_err2", int'(i2_err_count), 3);
    check("sat_locked", int'(locked), 1);
    drive(1, seq[(t + 5) % 14], 1); t++;
    drive(0, 0, 0);
    check("clr_vs_inc_err8", int'(err_count), 0);
    check("clr_vs_inc_err2", int'(i2_err_count), 0);

    // reset asserted mid-SYNC clears outputs without waiting for an edge
    apply_reset();
    drive(1, 8, 0); drive(1, 7, 0); drive(0, 0, 0);
    check("pre_rst_index", int'(index_out), 1);
    apply_reset();

    // randomized traffic against the model
    tx = 0;
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        apply_reset();
      end else if (r < 12) begin
        drive(0, 0, 0);
      end else if (r < 16) begin
        drive($urandom_range(0, 1), tx, 1);
      end else if (r < 30) begin
        drive(1, $urandom_range(0, 15), 0);
        tx = (tx + 1) % 14;
      end else begin
        drive(1, seq[tx], 0);
        tx = (tx + 1) % 14;
      end
    end
    drive(0, 0, 0);
    drive(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
